// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit load/store port onto a 16-bit asynchronous SRAM.
// Each word access runs as two half-word accesses, low half first, and each half is held
// for WAIT_CYCLES cycles. ready drops while an access is in flight.
// Optional feature: define SRAM_CTRL_RANGE_CHECK_EN to finish out-of-window accesses at
// once, with no SRAM strobe. Out-of-window reads return zero.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_dq_oe,
  output logic        o_sram_we_n
);

  localparam logic [31:0] AddrBase = 32'(ADDR_BASE);
  localparam logic [3:0]  CntLast  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StDone} state_e;

  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_read_data;
  logic        w_last;
  logic [29:0] w_offset;
  logic        w_oor;
  logic        w_unused;

  // Word offset from the window base; the two byte-lane bits never take part.
  assign w_offset = i_address[31:2] - AddrBase[31:2];
  assign w_last   = (r_cnt == CntLast);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  assign w_oor = (i_address[31:2] < AddrBase[31:2]) || (w_offset[29:17] != '0);
`else
  // Without the check the word index simply wraps onto the SRAM.
  assign w_oor = 1'b0;
`endif

  assign w_unused = ^{i_address[1:0], w_offset[29:17]};

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= StIdle;
    else        r_state <= w_next_state;
  end

  // Next-state logic: writes win over reads; each half ends on its last wait cycle.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_wr_en)      w_next_state = w_oor ? StDone : StWrLo;
        else if (i_rd_en) w_next_state = w_oor ? StDone : StRdLo;
      end
      StRdLo: if (w_last) w_next_state = StRdHi;
      StRdHi: if (w_last) w_next_state = StDone;
      StWrLo: if (w_last) w_next_state = StWrHi;
      StWrHi: if (w_last) w_next_state = StDone;
      StDone: w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // Wait counter, cleared on every state change.
  always_ff @(posedge i_clk) begin
    if (!i_rst)                       r_cnt <= '0;
    else if (w_next_state != r_state) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 4'd1;
  end

  // Read data capture: each half is sampled on the last cycle of its state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_read_data <= '0;
    end else if (r_state == StRdLo && w_last) begin
      r_read_data[15:0] <= i_sram_dq_in;
    end else if (r_state == StRdHi && w_last) begin
      r_read_data[31:16] <= i_sram_dq_in;
    end else if (r_state == StIdle && i_rd_en && !i_wr_en && w_oor) begin
      r_read_data <= '0;
    end
  end

  assign o_read_data = r_read_data;

  // Output decode: the SRAM bus is quiet outside the four access states.
  always_comb begin
    o_ready       = 1'b0;
    o_sram_addr   = '0;
    o_sram_dq_out = '0;
    o_sram_dq_oe  = 1'b0;
    o_sram_we_n   = 1'b1;
    unique case (r_state)
      StIdle: o_ready = !(i_rd_en || i_wr_en);
      StRdLo: o_sram_addr = {w_offset[16:0], 1'b0};
      StRdHi: o_sram_addr = {w_offset[16:0], 1'b1};
      StWrLo: begin
        o_sram_addr   = {w_offset[16:0], 1'b0};
        o_sram_dq_out = i_write_data[15:0];
        o_sram_dq_oe  = 1'b1;
        o_sram_we_n   = 1'b0;
      end
      StWrHi: begin
        o_sram_addr   = {w_offset[16:0], 1'b1};
        o_sram_dq_out = i_write_data[31:16];
        o_sram_dq_oe  = 1'b1;
        o_sram_we_n   = 1'b0;
      end
      StDone: o_ready = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, number of clock cycles each 16-bit SRAM half-access is held (legal 1..15).
REQ-002 Parameter: ADDR_BASE, 1024, byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  write request from the memory stage.
REQ-006 rd_en  input  1  read request from the memory stage.
REQ-007 address  input  32  byte address; bits [1:0] ignored.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data, registered.
REQ-010 ready  output  1  high = no access pending; pipeline freezes while low.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_dq_oe  output  1  drive enable for data bus (high only in write states).
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-017 IDLE: wr_en -> WR_LO; else rd_en -> RD_LO; else stay. wr_en has priority when both are high.
REQ-018 Each of RD_LO, RD_HI, WR_LO, WR_HI lasts exactly WAIT_CYCLES cycles via a 4-bit counter cleared on every state change. Order: LO then HI, then DONE.
REQ-019 DONE lasts one cycle, then IDLE unconditionally; a request still high in the following IDLE cycle is a new access.
REQ-020 ready is combinational: 1 in DONE and in IDLE with rd_en=wr_en=0; 0 otherwise, including the IDLE cycle in which a request is accepted.
REQ-021 Word index = (address - ADDR_BASE) >> 2. sram_addr = {word_index[16:0], h}, with h=0 in LO states and h=1 in HI states. sram_addr is 0 in IDLE/DONE.
REQ-022 Write: sram_dq_out = write_data[15:0] in WR_LO and write_data[31:16] in WR_HI. sram_we_n=0 and sram_dq_oe=1 throughout both states; otherwise sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-023 Read: sram_dq_in is captured into read_data[15:0] on the last RD_LO cycle and into read_data[31:16] on the last RD_HI cycle. read_data holds until the next read overwrites it; writes never change it.
REQ-024 Latency: a request accepted in cycle t gives ready=1 in cycle t+2*WAIT_CYCLES+1 (t+5 at default).
REQ-025 The requester holds address, write_data, rd_en and wr_en stable while ready=0. The controller latches nothing else.

Reset
REQ-026 rst=0 at a rising edge forces IDLE and clears the counter and read_data to 0. This applies mid-access: the access is abandoned, no further SRAM strobes occur, and no DONE is issued.
REQ-027 After reset: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, and ready=1 unless a request is present.

Configuration
REQ-028 Macro SRAM_CTRL_RANGE_CHECK_EN defined: an address below ADDR_BASE or with word_index >= 2^17 is treated as follows.
- IDLE goes directly to DONE with no SRAM strobe.
- For reads, read_data is set to 0 at the DONE transition.
REQ-029 Macro undefined: no check; the word index wraps modulo 2^17 and all accesses go to SRAM.

Verification
REQ-030 Write address=1024, data=0xDEADBEEF, default params -> WR_LO: sram_addr=0, dq_out=0xBEEF, we_n=0 for 2 cycles; WR_HI: sram_addr=1, dq_out=0xDEAD for 2 cycles; ready=1 at t+5.
REQ-031 Read address=1024 with SRAM model returning stored halves -> read_data=0xDEADBEEF at t+5, we_n=1 and oe=0 throughout.
REQ-032 rd_en=wr_en=1 at address=1032, data=0x12345678 -> write performed at sram_addr 4/5; read_data unchanged.
REQ-033 rst=0 asserted in the second WR_LO cycle -> next cycle state is IDLE, we_n=1, no WR_HI strobe, read_data=0.
REQ-034 SRAM_CTRL_RANGE_CHECK_EN defined, read address=0 -> ready=1 at t+1, read_data=0, no SRAM strobe; macro undefined -> normal 5-cycle access to wrapped sram_addr.
REQ-035 WAIT_CYCLES=1, back-to-back reads at 1024 and 1028 -> ready pulses at t+3 and t+7; read_data updates at each pulse.
